load_align_unit: RTL

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

---
 rtl/lau_pkg.sv | 15 +
 rtl/lau_extend.sv | 33 +++
 rtl/load_align_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lau_pkg.sv
// rtl/lau_pkg.sv - shared size encodings and size-to-bytes helper for the load align unit
package lau_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  function automatic logic [3:0] size_bytes(input size_e sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/lau_extend.sv
// rtl/lau_extend.sv - truncates a right-aligned value to the access size and sign/zero extends it
module lau_extend
  import lau_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  input  size_e             size_i,
  input  logic              sign_i,
  output logic [DATA_W-1:0] result_o
);

  localparam int NB = DATA_W / 8;

  logic [3:0] nbytes;
  logic       fill;

  // Full-width sizes keep every byte, so the fill value never reaches the result.
  always_comb begin
    nbytes   = size_bytes(size_i);
    fill     = 1'b0;
    result_o = '0;
    for (int i = 0; i < NB; i++) begin
      if (4'(i) == nbytes - 4'd1) begin
        fill = sign_i & data_i[8*i+7];
      end
    end
    for (int i = 0; i < NB; i++) begin
      result_o[8*i +: 8] = (4'(i) < nbytes) ? data_i[8*i +: 8] : {8{fill}};
    end
  end

endmodule

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - two-stage load data aligner; LOAD_ALIGN_MISALIGN_TRAP_EN adds misalign flag and counter
module load_align_unit
  import lau_pkg::*;
#(
  parameter int  DATA_W = 32,
  parameter int  CNT_W  = 16,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic              I_LAU_clk,
  input  logic              I_LAU_reset_n,
  input  logic              I_LAU_valid,
  output logic              O_LAU_ready,
  input  logic [DATA_W-1:0] I_LAU_data,
  input  logic [OFF_W-1:0]  I_LAU_offset,
  input  logic [1:0]        I_LAU_size,
  input  logic              I_LAU_sign,
  input  logic              I_LAU_flush,
  output logic              O_LAU_valid,
  input  logic              I_LAU_ready,
  output logic [DATA_W-1:0] O_LAU_result
`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
  ,
  output logic              O_LAU_misalign,
  output logic [CNT_W-1:0]  O_LAU_err_count
`endif
);

  if ((DATA_W != 32 && DATA_W != 64) || CNT_W < 1) begin : g_param_check
    $error("load_align_unit: unsupported DATA_W or CNT_W");
  end

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  size_e             s1_size_q, s1_size_d;
  logic              s1_sign_q, s1_sign_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_result_q, s2_result_d;

  size_e             size_eff;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext_result;
  logic              xfer;
  logic              s1_adv;
  logic              accept;

  // A dword request on a 32-bit datapath degrades to a word access.
  always_comb begin
    size_eff = size_e'(I_LAU_size);
    if (NB == 4 && size_eff == SZ_DWORD) begin
      size_eff = SZ_WORD;
    end
  end

  assign shifted     = I_LAU_data >> {I_LAU_offset, 3'b000};
  assign xfer        = s2_valid_q & I_LAU_ready;
  assign s1_adv      = ~s2_valid_q | xfer;
  assign O_LAU_ready = ~I_LAU_flush & (~s1_valid_q | s1_adv);
  assign accept      = I_LAU_valid & O_LAU_ready;

  lau_extend #(
    .DATA_W (DATA_W)
  ) u_extend (
    .data_i   (s1_data_q),
    .size_i   (s1_size_q),
    .sign_i   (s1_sign_q),
    .result_o (ext_result)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_size_d   = s1_size_q;
    s1_sign_d   = s1_sign_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    if (I_LAU_flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_adv) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_result_d = ext_result;
        end
      end
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_data_d  = shifted;
        s1_size_d  = size_eff;
        s1_sign_d  = I_LAU_sign;
      end else if (s1_adv) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge I_LAU_clk or negedge I_LAU_reset_n) begin
    if (!I_LAU_reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_size_q   <= SZ_BYTE;
      s1_sign_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_size_q   <= s1_size_d;
      s1_sign_q   <= s1_sign_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
    end
  end

  assign O_LAU_valid  = s2_valid_q;
  assign O_LAU_result = s2_result_q;

`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
  logic [3:0]       acc_bytes;
  logic             acc_mis;
  logic             s1_mis_q, s1_mis_d;
  logic             s2_mis_q, s2_mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_bytes = size_bytes(size_eff);
    acc_mis   = (NB == 4 && I_LAU_size == SZ_DWORD)
              || ((4'(I_LAU_offset) & (acc_bytes - 4'd1)) != 4'd0)
              || ((4'(I_LAU_offset) + acc_bytes) > 4'(NB));
  end

  // The flag travels with its entry; the counter saturates rather than wrapping.
  always_comb begin
    s1_mis_d = s1_mis_q;
    s2_mis_d = s2_mis_q;
    cnt_d    = cnt_q;
    if (!I_LAU_flush) begin
      if (s1_adv && s1_valid_q) begin
        s2_mis_d = s1_mis_q;
      end
      if (accept) begin
        s1_mis_d = acc_mis;
      end
    end
    if (xfer && s2_mis_q && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge I_LAU_clk or negedge I_LAU_reset_n) begin
    if (!I_LAU_reset_n) begin
      s1_mis_q <= 1'b0;
      s2_mis_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_mis_q <= s1_mis_d;
      s2_mis_q <= s2_mis_d;
      cnt_q    <= cnt_d;
    end
  end

  assign O_LAU_misalign  = s2_valid_q & s2_mis_q;
  assign O_LAU_err_count = cnt_q;
`endif

endmodule
